multicycle_sequencer: RTL

- Sequences the five-stage datapath one stage per cycle by driving each pipeline register's write enable, the PC, RAM and register-file write strobes, and the datapath's synchronous state reset.
- Adds three things to a fixed stage rotation: variable-latency memory access (slow or MMIO devices such as UART), a halt/resume request, and a retired-instruction counter.
- Sits at CPU top level and drives the stage write-enable inputs directly.

---
 rtl/multicycle_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// Multicycle sequencer for the five-stage datapath: one stage strobe per cycle,
// with reset hold, variable-latency MEM wait, halt/resume and a retired counter.
module multicycle_sequencer #(
  parameter int RESET_HOLD_CYCLES = 4,
  parameter int WAIT_TIMEOUT      = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        halt_req,
  input  logic        mem_ext_req,
  input  logic        mem_ext_ready,
  output logic        state_reset_n,
  output logic        wb_if_wren,
  output logic        if_id_wren,
  output logic        id_ex_wren,
  output logic        ex_mem_wren,
  output logic        mem_wb_wren,
  output logic        ram_wren,
  output logic        reg_wren,
  output logic        pc_wren,
  output logic        halted,
  output logic        timeout_err,
  output logic [31:0] retired_count
);

  localparam int HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int WAIT_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_TIMEOUT - 1);

  typedef enum logic [3:0] {
    RESET_HOLD,
    FETCH,
    DECODE,
    EXECUTE,
    MEM_LATCH,
    MEM_ACCESS,
    MEM_WAIT,
    WB_LATCH,
    COMMIT,
    HALT
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               wait_expired;

  always_comb begin
    state_next   = state;
    wait_expired = 1'b0;
    case (state)
      RESET_HOLD: if (hold_cnt == HOLD_LAST) state_next = FETCH;
      FETCH:      state_next = DECODE;
      DECODE:     state_next = EXECUTE;
      EXECUTE:    state_next = MEM_LATCH;
      MEM_LATCH:  state_next = MEM_ACCESS;
      MEM_ACCESS: state_next = mem_ext_req ? MEM_WAIT : WB_LATCH;
      MEM_WAIT: begin
        // Ready is checked first so it wins over a coincident timeout.
        if (mem_ext_ready) begin
          state_next = WB_LATCH;
        end else if (wait_cnt == WAIT_LAST) begin
          wait_expired = 1'b1;
          state_next   = HALT;
        end
      end
      WB_LATCH:   state_next = COMMIT;
      COMMIT:     state_next = halt_req ? HALT : FETCH;
      HALT:       if (!halt_req && !timeout_err) state_next = FETCH;
      default:    state_next = RESET_HOLD;
    endcase
  end

  // Outputs are registered from the next state, so each one is a pure
  // decode of the state register as seen during the cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= RESET_HOLD;
      hold_cnt      <= '0;
      wait_cnt      <= '0;
      state_reset_n <= 1'b0;
      wb_if_wren    <= 1'b0;
      if_id_wren    <= 1'b0;
      id_ex_wren    <= 1'b0;
      ex_mem_wren   <= 1'b0;
      mem_wb_wren   <= 1'b0;
      ram_wren      <= 1'b0;
      reg_wren      <= 1'b0;
      pc_wren       <= 1'b0;
      halted        <= 1'b0;
      timeout_err   <= 1'b0;
      retired_count <= '0;
    end else begin
      state <= state_next;
      case (state)
        RESET_HOLD: hold_cnt <= hold_cnt + 1'b1;
        MEM_ACCESS: wait_cnt <= '0;
        MEM_WAIT:   if (!mem_ext_ready) wait_cnt <= wait_cnt + 1'b1;
        COMMIT:     retired_count <= retired_count + 32'd1;
        default:    ;
      endcase
      if (wait_expired) timeout_err <= 1'b1;
      state_reset_n <= (state_next != RESET_HOLD);
      if_id_wren    <= (state_next == DECODE);
      id_ex_wren    <= (state_next == EXECUTE);
      ex_mem_wren   <= (state_next == MEM_LATCH);
      ram_wren      <= (state_next == MEM_ACCESS);
      mem_wb_wren   <= (state_next == WB_LATCH);
      reg_wren      <= (state_next == COMMIT);
      wb_if_wren    <= (state_next == COMMIT);
      pc_wren       <= (state_next == COMMIT);
      halted        <= (state_next == HALT);
    end
  end

endmodule
